// File: rtl/axi_lite_cfg_sequencer.sv
// axi_lite_cfg_sequencer: writes NUM_REGS AXI-Lite word registers from cfg_data_i on start_i.
// Optional readback verification of every register: define CFG_SEQ_READBACK_EN.
module axi_lite_cfg_sequencer #(
    parameter int          NUM_REGS  = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 255,
    localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [32*NUM_REGS-1:0]  cfg_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [1:0]              err_code_o,
    output logic [IDX_W-1:0]        err_idx_o,
    output logic [31:0]             axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [31:0]             axi_wdata,
    output logic [3:0]              axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
`ifdef CFG_SEQ_READBACK_EN
    output logic [31:0]             axi_araddr,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [31:0]             axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
`endif
    output logic                    axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_FINISH, S_RD_REQ, S_RD_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [32*NUM_REGS-1:0] shadow_q, shadow_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [1:0]             code_q, code_d;
    logic [IDX_W-1:0]       eidx_q, eidx_d;

    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic        last;
    logic        tmo;
    logic        req_on;

    assign cur_addr = BASE_ADDR + (32'(idx_q) << 2);
    assign cur_data = shadow_q[32*idx_q +: 32];
    assign last     = (idx_q == IDX_W'(NUM_REGS - 1));
    assign tmo      = (cnt_q == 8'(TIMEOUT - 1));
    // First WR_REQ cycle only sets up address/data; valids rise on the next one.
    assign req_on   = (state_q == S_WR_REQ) && (cnt_q != 8'd0);

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FINISH);
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign err_idx_o   = eidx_q;
    assign axi_awvalid = req_on && !aw_done_q;
    assign axi_wvalid  = req_on && !w_done_q;
    assign axi_awaddr  = (state_q == S_WR_REQ) ? cur_addr : 32'h0;
    assign axi_wdata   = (state_q == S_WR_REQ) ? cur_data : 32'h0;
    assign axi_wstrb   = 4'hF;
    assign axi_bready  = (state_q == S_WR_RESP);
`ifdef CFG_SEQ_READBACK_EN
    assign axi_arvalid = (state_q == S_RD_REQ);
    assign axi_araddr  = (state_q == S_RD_REQ) ? cur_addr : 32'h0;
    assign axi_rready  = (state_q == S_RD_RESP);
`endif

    // Next-state, handshake tracking, error capture and per-state cycle counter.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        code_d    = code_q;
        eidx_d    = eidx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shadow_d  = cfg_data_i;
                    err_d     = 1'b0;
                    code_d    = 2'b00;
                    eidx_d    = '0;
                    idx_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                aw_done_d = aw_done_q | (axi_awvalid & axi_awready);
                w_done_d  = w_done_q | (axi_wvalid & axi_wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end else if (tmo) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b1;
                    code_d    = 2'b10;
                    eidx_d    = idx_q;
                    state_d   = S_FINISH;
                end
            end
            S_WR_RESP: begin
                if (axi_bvalid) begin
                    if (axi_bresp != 2'b00) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        eidx_d  = idx_q;
                        state_d = S_FINISH;
                    end else if (last) begin
`ifdef CFG_SEQ_READBACK_EN
                        idx_d   = '0;
                        state_d = S_RD_REQ;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_WR_REQ;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    eidx_d  = idx_q;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
`ifdef CFG_SEQ_READBACK_EN
            S_RD_REQ: begin
                if (axi_arready) begin
                    state_d = S_RD_RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    eidx_d  = idx_q;
                    state_d = S_FINISH;
                end
            end
            S_RD_RESP: begin
                if (axi_rvalid) begin
                    if (axi_rresp != 2'b00 || axi_rdata != cur_data) begin
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                        eidx_d  = idx_q;
                        state_d = S_FINISH;
                    end else if (last) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_RD_REQ;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    eidx_d  = idx_q;
                    state_d = S_FINISH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cnt_d = (state_d != state_q || state_q == S_IDLE) ? 8'd0 : cnt_q + 8'd1;
    end

    // State and datapath registers; reset aborts any handshake in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            eidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            code_q    <= code_d;
            eidx_q    <= eidx_d;
        end
    end

endmodule
